mmio_timer: RTL and testbench
=============================

Name: mmio_timer

Overview:
- Memory-mapped countdown timer that acts as a responder on the processor's data-memory bus (wEn/addr/dataIn/dataOut).
- Sits beside the RAM in the top-level wrapper. The wrapper routes dataOut to the processor's read-data input whenever hit_q is high.
- Read timing matches the RAM: registered, 1-cycle latency. This lets software poll or configure a timer with ordinary sw/lw instructions.

Parameters:
- BASE_ADDR, 12'hF00, word address of the register window. Must be 8-word aligned (bits [2:0] = 0).
- WIDTH, 32, width of the COUNT, LOAD and PRESCALE registers. Range 8..32; values are zero-extended on read.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wEn  in  1  bus write enable.
- addr  in  12  bus word address.
- dataIn  in  32  bus write data.
- dataOut  out  32  registered read data; 0 when the previous cycle was not a hit.
- hit_q  out  1  registered: the previous cycle's addr was inside the window. Used as the read-mux select.
- irq  out  1  level interrupt = STATUS.expired & CTRL.irq_en.

Behaviour:
- Address decode: hit = (addr[11:3] == BASE_ADDR[11:3]). Offset = addr[2:0].
- Register map:
  - 0 CTRL, R/W: bit0 en, bit1 auto_reload, bit2 irq_en.
  - 1 LOAD, R/W. A write also copies the value into COUNT and clears the prescale counter.
  - 2 COUNT, read-only; writes are ignored.
  - 3 STATUS, bit0 expired: sticky, write-1-to-clear.
  - 4 PRESCALE, R/W.
  - 5..7 read 0; writes are ignored.
- Write: when wEn & hit, the register at the offset updates at the clock edge. Bits above WIDTH (and above bit 2 for CTRL) are dropped.
- Read: every cycle, dataOut <= hit ? reg[offset] : 0, and hit_q <= hit.
  - A read in the same cycle as a write returns the pre-write value.
  - wEn reads also return data; the wrapper ignores it.
- Prescaler: while en=1, pcnt increments each cycle. When pcnt == PRESCALE, tick=1 and pcnt <= 0. PRESCALE=0 gives a tick every cycle. While en=0, pcnt holds.
- Counter, on tick:
  - If COUNT != 0: COUNT <= COUNT-1.
  - If COUNT == 0 (expire event): expired <= 1, then:
    - auto_reload=1: COUNT <= LOAD.
    - auto_reload=0: en <= 0, COUNT stays 0.
  - Consequence: expiry fires LOAD+1 ticks after start (LOAD=0 expires on the first tick).
- Simultaneous events:
  - A STATUS W1C write in the same cycle as an expire event: set wins, expired stays 1.
  - A CTRL write in the same cycle as an auto-disable: the written value wins.
  - A LOAD write in the same cycle as a tick: the written value wins, pcnt resets to 0, and no decrement occurs.
- Reset (any cycle, including mid-count): CTRL=0, LOAD=0, COUNT=0, STATUS=0, PRESCALE=0, pcnt=0, dataOut=0, hit_q=0, irq=0. Takes effect at the next edge while reset is high.

Optional Feature:
- Macro MMIO_TIMER_CAPTURE_EN.
- When defined:
  - Offset 5 becomes CAPTURE, read-only.
  - Any write to offset 5 snapshots the live COUNT into CAPTURE.
  - Offset 6 becomes OVERRUN, read-only: it increments (saturating at all-ones) on each expire event that occurs while expired is already 1. A STATUS W1C write clears OVERRUN.
  - Reset clears both registers.
- When not defined: offsets 5..7 read 0, and no capture/overrun logic is generated.

Decomposition:
- Shared package mmio_pkg holds:
  - Offset constants: OFF_CTRL=0, OFF_LOAD=1, OFF_COUNT=2, OFF_STATUS=3, OFF_PRESCALE=4, OFF_CAPTURE=5, OFF_OVERRUN=6.
  - CTRL bit indices: EN=0, AUTO=1, IRQEN=2.
  - The default timer base 12'hF00.
- One sub-module: mmio_prescaler (pcnt, compare, tick output; enable and clear inputs). The counter, register file and read mux stay in mmio_timer.

Test Plan:
- Reset, then read all 8 offsets -> dataOut=0 each cycle after access, hit_q=1; addr 12'h0FF -> hit_q=0, dataOut=0.
- Write LOAD=3, PRESCALE=0, CTRL=1 -> COUNT reads 3,2,1,0 on successive ticks; expired=1 on the 4th tick; en auto-clears; CTRL reads 0.
- LOAD=2, PRESCALE=4, CTRL=3 (auto-reload) -> a tick every 5 cycles; expired sets after 15 cycles; COUNT reloads to 2; continues counting.
- CTRL=5 with expired=1 -> irq=1. Write STATUS=1 -> irq=0 next cycle. Write STATUS=1 in the same cycle as an expire event -> expired stays 1.
- Assert reset mid-count (COUNT=7, en=1) -> all registers 0, irq=0, no further decrement.
- With MMIO_TIMER_CAPTURE_EN: write offset 5 when COUNT=9 -> CAPTURE reads 9. Two expiries without a clear -> OVERRUN=1. STATUS W1C -> OVERRUN=0.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: register offsets, CTRL bit indices and default base address for mmio_timer.
package mmio_pkg;
   localparam logic [2:0] OFF_CTRL     = 3'd0;
   localparam logic [2:0] OFF_LOAD     = 3'd1;
   localparam logic [2:0] OFF_COUNT    = 3'd2;
   localparam logic [2:0] OFF_STATUS   = 3'd3;
   localparam logic [2:0] OFF_PRESCALE = 3'd4;
   localparam logic [2:0] OFF_CAPTURE  = 3'd5;
   localparam logic [2:0] OFF_OVERRUN  = 3'd6;
   localparam int EN    = 0;
   localparam int AUTO  = 1;
   localparam int IRQEN = 2;
   localparam logic [11:0] TIMER_BASE = 12'hF00;
endpackage

// File: rtl/mmio_prescaler.sv
// mmio_prescaler: divides the clock by PRESCALE+1 while enabled; clr restarts the divide.
module mmio_prescaler #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] prescale,
   output logic             tick
);
   logic [WIDTH-1:0] pcnt;
   assign tick = en && pcnt == prescale;
   always_ff @(posedge clock)
      if (reset || clr) pcnt <= '0;
      else if (en) pcnt <= tick ? '0 : pcnt + 1'b1;
endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped countdown timer on the data-memory bus, 1-cycle registered reads.
// Define MMIO_TIMER_CAPTURE_EN to add CAPTURE (offset 5) and OVERRUN (offset 6).
module mmio_timer
   import mmio_pkg::*;
#(
   parameter logic [11:0] BASE_ADDR = TIMER_BASE,
   parameter int          WIDTH     = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wEn,
   input  logic [11:0] addr,
   input  logic [31:0] dataIn,
   output logic [31:0] dataOut,
   output logic        hit_q,
   output logic        irq
);
   logic             hit, wr, tick, expire, w1c, expired;
   logic [2:0]       off, ctrl;
   logic [WIDTH-1:0] load, count, prescale;
   logic [31:0]      rd;
`ifdef MMIO_TIMER_CAPTURE_EN
   logic [WIDTH-1:0] capture, overrun;
`endif
   assign hit    = addr[11:3] == BASE_ADDR[11:3];
   assign off    = addr[2:0];
   assign wr     = wEn & hit;
   assign w1c    = wr && off == OFF_STATUS && dataIn[0];
   assign expire = tick && count == '0;
   assign irq    = expired & ctrl[IRQEN];

   mmio_prescaler #(.WIDTH(WIDTH)) u_prescaler (
      .clock    (clock),
      .reset    (reset),
      .en       (ctrl[EN]),
      .clr      (wr && off == OFF_LOAD),
      .prescale (prescale),
      .tick     (tick)
   );

   always_comb begin
      rd = '0;
      case (off)
         OFF_CTRL:     rd = {29'd0, ctrl};
         OFF_LOAD:     rd = 32'(load);
         OFF_COUNT:    rd = 32'(count);
         OFF_STATUS:   rd = {31'd0, expired};
         OFF_PRESCALE: rd = 32'(prescale);
`ifdef MMIO_TIMER_CAPTURE_EN
         OFF_CAPTURE:  rd = 32'(capture);
         OFF_OVERRUN:  rd = 32'(overrun);
`endif
         default:      rd = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ctrl     <= '0;
         load     <= '0;
         count    <= '0;
         expired  <= 1'b0;
         prescale <= '0;
         dataOut  <= '0;
         hit_q    <= 1'b0;
`ifdef MMIO_TIMER_CAPTURE_EN
         capture  <= '0;
         overrun  <= '0;
`endif
      end else begin
         hit_q   <= hit;
         dataOut <= hit ? rd : '0;
         // bus writes take priority over the counter's own updates
         if (wr && off == OFF_CTRL) ctrl <= dataIn[2:0];
         else if (expire && !ctrl[AUTO]) ctrl[EN] <= 1'b0;
         if (wr && off == OFF_LOAD) load <= dataIn[WIDTH-1:0];
         if (wr && off == OFF_PRESCALE) prescale <= dataIn[WIDTH-1:0];
         if (wr && off == OFF_LOAD) count <= dataIn[WIDTH-1:0];
         else if (tick) count <= count != '0 ? count - 1'b1 : ctrl[AUTO] ? load : '0;
         if (expire) expired <= 1'b1;
         else if (w1c) expired <= 1'b0;
`ifdef MMIO_TIMER_CAPTURE_EN
         if (wr && off == OFF_CAPTURE) capture <= count;
         if (expire && expired) overrun <= &overrun ? overrun : overrun + 1'b1;
         else if (w1c) overrun <= '0;
`endif
      end
   end
endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed and randomized bus traffic, scoreboarded against a register-level model.
module tb_mmio_timer;
   logic        clock = 1'b0, reset = 1'b1, wEn = 1'b0;
   logic [11:0] addr = '0;
   logic [31:0] dataIn = '0, dataOut;
   logic        hit_q, irq;
   int total = 0, bad = 0;

   typedef struct packed { logic h; logic [31:0] d; logic i; } exp_t;
   exp_t q[$];
   exp_t got_e;

   bit m_en, m_auto, m_irqen, m_exp;
   int unsigned m_load, m_cnt, m_pre, m_pcnt, m_cap, m_ovr;

   mmio_timer dut (
      .clock   (clock),
      .reset   (reset),
      .wEn     (wEn),
      .addr    (addr),
      .dataIn  (dataIn),
      .dataOut (dataOut),
      .hit_q   (hit_q),
      .irq     (irq)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] m_read(int off);
      case (off)
         0: return {29'd0, m_irqen, m_auto, m_en};
         1: return m_load;
         2: return m_cnt;
         3: return {31'd0, m_exp};
         4: return m_pre;
`ifdef MMIO_TIMER_CAPTURE_EN
         5: return m_cap;
         6: return m_ovr;
`endif
         default: return 32'd0;
      endcase
   endfunction

   // Advances the model over one clock edge and returns what the bus should show after it.
   function automatic exp_t model(bit r, bit w, logic [11:0] a, logic [31:0] d);
      exp_t e;
      bit hit, wr, tk, ex, clr;
      int off;
      int unsigned n_cnt, n_pcnt;
      if (r) begin
         {m_en, m_auto, m_irqen, m_exp} = '0;
         {m_load, m_cnt, m_pre, m_pcnt, m_cap, m_ovr} = '0;
         return '0;
      end
      hit = a >= 12'hF00 && a <= 12'hF07;
      off = int'(a[2:0]);
      e.h = hit;
      e.d = hit ? m_read(off) : 32'd0;
      wr = w && hit;
      clr = wr && off == 3 && d[0];
      tk = m_en && m_pcnt == m_pre;
      ex = tk && m_cnt == 0;
      if (wr && off == 1) begin
         n_pcnt = 0;
         n_cnt = d;
      end else begin
         n_pcnt = !m_en ? m_pcnt : tk ? 0 : m_pcnt + 1;
         n_cnt = !tk ? m_cnt : m_cnt != 0 ? m_cnt - 1 : m_auto ? m_load : 0;
      end
      if (wr && off == 5) m_cap = m_cnt;
      if (ex && m_exp) m_ovr = m_ovr == 32'hFFFF_FFFF ? m_ovr : m_ovr + 1;
      else if (clr) m_ovr = 0;
      m_exp = ex ? 1'b1 : clr ? 1'b0 : m_exp;
      if (wr && off == 0) {m_irqen, m_auto, m_en} = d[2:0];
      else if (ex && !m_auto) m_en = 1'b0;
      if (wr && off == 1) m_load = d;
      if (wr && off == 4) m_pre = d;
      m_cnt = n_cnt;
      m_pcnt = n_pcnt;
      e.i = m_exp & m_irqen;
      return e;
   endfunction

   task automatic step(input bit r, input bit w, input logic [11:0] a, input logic [31:0] d);
      reset = r; wEn = w; addr = a; dataIn = d;
      q.push_back(model(r, w, a, d));
      @(posedge clock);
      #1;
   endtask

   task automatic wr_reg(input logic [11:0] a, input logic [31:0] d);
      step(1'b0, 1'b1, a, d);
   endtask

   task automatic chk_read(input string name, input logic [11:0] a, input logic [31:0] want);
      step(1'b0, 1'b0, a, 32'd0);
      total++;
      if (dataOut !== want) begin
         bad++;
         $display("FAIL %s: dataOut=%h want %h", name, dataOut, want);
      end
   endtask

   initial forever begin
      @(negedge clock);
      if (q.size() > 0) begin
         got_e = q.pop_front();
         total++;
         if (hit_q !== got_e.h || dataOut !== got_e.d || irq !== got_e.i) begin
            bad++;
            $display("FAIL bus: hit_q=%0b dataOut=%h irq=%0b want hit_q=%0b dataOut=%h irq=%0b",
                     hit_q, dataOut, irq, got_e.h, got_e.d, got_e.i);
         end
      end
   end

   initial begin
      repeat (3) step(1'b1, 1'b0, 12'h000, 32'd0);
      for (int i = 0; i < 8; i++) chk_read("reset_reg", 12'hF00 + 12'(i), 32'd0);
      step(1'b0, 1'b0, 12'h0FF, 32'd0);
      total++;
      if (hit_q !== 1'b0) begin
         bad++;
         $display("FAIL miss_hit: hit_q=%0b want 0", hit_q);
      end
      // one-shot countdown from 3
      wr_reg(12'hF01, 32'd3);
      wr_reg(12'hF04, 32'd0);
      wr_reg(12'hF00, 32'd1);
      chk_read("count3", 12'hF02, 32'd3);
      chk_read("count2", 12'hF02, 32'd2);
      chk_read("count1", 12'hF02, 32'd1);
      chk_read("count0", 12'hF02, 32'd0);
      chk_read("expired", 12'hF03, 32'd1);
      chk_read("auto_off", 12'hF00, 32'd0);
      chk_read("count_hold", 12'hF02, 32'd0);
      // auto-reload with prescale
      wr_reg(12'hF03, 32'd1);
      wr_reg(12'hF01, 32'd2);
      wr_reg(12'hF04, 32'd4);
      wr_reg(12'hF00, 32'd3);
      repeat (40) step(1'b0, 1'b0, 12'hF02, 32'd0);
      chk_read("reload_ctrl", 12'hF00, 32'd3);
      // interrupt and W1C vs expire
      wr_reg(12'hF00, 32'd5);
      step(1'b0, 1'b0, 12'hF03, 32'd0);
      wr_reg(12'hF03, 32'd1);
      wr_reg(12'hF01, 32'd0);
      wr_reg(12'hF04, 32'd0);
      wr_reg(12'hF00, 32'd5);
      wr_reg(12'hF03, 32'd1);
      chk_read("set_wins", 12'hF03, 32'd1);
      // reset mid-count
      wr_reg(12'hF03, 32'd1);
      wr_reg(12'hF01, 32'd7);
      wr_reg(12'hF04, 32'd3);
      wr_reg(12'hF00, 32'd1);
      repeat (2) step(1'b0, 1'b0, 12'hF02, 32'd0);
      step(1'b1, 1'b0, 12'hF02, 32'd0);
      chk_read("rst_count", 12'hF02, 32'd0);
      repeat (5) step(1'b0, 1'b0, 12'hF02, 32'd0);
      chk_read("rst_ctrl", 12'hF00, 32'd0);
`ifdef MMIO_TIMER_CAPTURE_EN
      wr_reg(12'hF01, 32'd9);
      wr_reg(12'hF05, 32'd0);
      chk_read("capture", 12'hF05, 32'd9);
      wr_reg(12'hF01, 32'd0);
      wr_reg(12'hF00, 32'd3);
      step(1'b0, 1'b0, 12'hF06, 32'd0);
      wr_reg(12'hF00, 32'd0);
      chk_read("overrun1", 12'hF06, 32'd1);
      wr_reg(12'hF03, 32'd1);
      chk_read("overrun0", 12'hF06, 32'd0);
`endif
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [11:0] a;
         logic [31:0] d;
         a = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'hF00 + 12'($urandom_range(0, 7));
         d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 6));
         step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, a, d);
      end
      repeat (3) @(negedge clock);
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d entries left, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
